multi_channel_clock_divider: RTL and testbench

//  Generates NUM_CH independent divided clock enables/levels from CLK100MHZ.

---
 rtl/multi_channel_clock_divider.sv | 137 +++++++++++++
 tb/tb_multi_channel_clock_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable clock dividers with registered level and tick outputs,
// configured through a valid/ready write port. Optional SYNC input under CLKDIV_SYNC_EN.
module multi_channel_clock_divider #(
  parameter int NUM_CH     = 4,
  parameter int CW         = 24,
  parameter int DEF_PERIOD = 1_000_000,
  parameter int DEF_HIGH   = 500_000,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CHW-1:0]    CFG_CH,
  input  logic [CW-1:0]     CFG_PERIOD,
  input  logic [CW-1:0]     CFG_HIGH,
`ifdef CLKDIV_SYNC_EN
  input  logic              SYNC,
`endif
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
);

  // Handshake: a config write transfers on any CLK100MHZ edge where CFG_VALID && CFG_READY.
  // READY is low only while the addressed channel still holds an unapplied shadow config.

  logic [CW-1:0]     cnt_q    [NUM_CH];
  logic [CW-1:0]     per_q    [NUM_CH];
  logic [CW-1:0]     hi_q     [NUM_CH];
  logic [CW-1:0]     sh_per_q [NUM_CH];
  logic [CW-1:0]     sh_hi_q  [NUM_CH];
  logic [NUM_CH-1:0] pend_q;

  logic [CW-1:0]     cnt_d    [NUM_CH];
  logic [CW-1:0]     per_d    [NUM_CH];
  logic [CW-1:0]     hi_d     [NUM_CH];
  logic [CW-1:0]     sh_per_d [NUM_CH];
  logic [CW-1:0]     sh_hi_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_d;
  logic              cfg_ready;
  logic [CW-1:0]     cfg_per_clamped;

  // Out-of-range channels always accept, so the write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CFG_CH == CHW'(i)) cfg_ready = !pend_q[i];
    end
  end

  assign CFG_READY       = cfg_ready;
  assign cfg_per_clamped = (CFG_PERIOD < CW'(2)) ? CW'(2) : CFG_PERIOD;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      per_d[i]    = per_q[i];
      hi_d[i]     = hi_q[i];
      sh_per_d[i] = sh_per_q[i];
      sh_hi_d[i]  = sh_hi_q[i];
      pend_d[i]   = pend_q[i];
      clk_d[i]    = CLK_OUT[i];
      tick_d[i]   = 1'b0;
`ifdef CLKDIV_SYNC_EN
      if (SYNC) begin
        if (pend_q[i]) begin
          per_d[i]  = sh_per_q[i];
          hi_d[i]   = sh_hi_q[i];
          pend_d[i] = 1'b0;
        end
        cnt_d[i] = '0;
        if (EN[i]) begin
          tick_d[i] = 1'b1;
          clk_d[i]  = (hi_d[i] != '0);
        end
      end else
`endif
      if (EN[i]) begin
        if (cnt_q[i] == per_q[i] - CW'(1)) begin
          // New period/high take effect on count 0 of the new period: no runt pulse.
          if (pend_q[i]) begin
            per_d[i]  = sh_per_q[i];
            hi_d[i]   = sh_hi_q[i];
            pend_d[i] = 1'b0;
          end
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          clk_d[i]  = (hi_d[i] != '0);
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          clk_d[i] = (cnt_d[i] < hi_q[i]);
        end
      end else if (pend_q[i]) begin
        // Parked at the last count so the channel restarts with a tick when EN rises.
        per_d[i]  = sh_per_q[i];
        hi_d[i]   = sh_hi_q[i];
        pend_d[i] = 1'b0;
        cnt_d[i]  = sh_per_q[i] - CW'(1);
      end
      if (CFG_VALID && cfg_ready && (CFG_CH == CHW'(i))) begin
        sh_per_d[i] = cfg_per_clamped;
        sh_hi_d[i]  = CFG_HIGH;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= CW'(DEF_PERIOD - 1);
        per_q[i]    <= CW'(DEF_PERIOD);
        hi_q[i]     <= CW'(DEF_HIGH);
        sh_per_q[i] <= CW'(DEF_PERIOD);
        sh_hi_q[i]  <= CW'(DEF_HIGH);
      end
      pend_q  <= '0;
      CLK_OUT <= '0;
      TICK    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        per_q[i]    <= per_d[i];
        hi_q[i]     <= hi_d[i];
        sh_per_q[i] <= sh_per_d[i];
        sh_hi_q[i]  <= sh_hi_d[i];
      end
      pend_q  <= pend_d;
      CLK_OUT <= clk_d;
      TICK    <= tick_d;
    end
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Randomized bench for multi_channel_clock_divider against a period/phase reference model.
// Three channels are used so that channel index 3 is a representable out-of-range target.
module tb_multi_channel_clock_divider;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DP  = 10;
  localparam int DH  = 5;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  always #5 clk = ~clk;

  multi_channel_clock_divider #(
    .NUM_CH(NCH), .CW(CW), .DEF_PERIOD(DP), .DEF_HIGH(DH)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .EN        (en),
    .CFG_VALID (cfg_valid),
    .CFG_READY (cfg_ready),
    .CFG_CH    (cfg_ch),
    .CFG_PERIOD(cfg_period),
    .CFG_HIGH  (cfg_high),
`ifdef CLKDIV_SYNC_EN
    .SYNC      (sync),
`endif
    .CLK_OUT   (clk_out),
    .TICK      (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: position within the current period plus the period/high in force.
  int m_pos  [NCH];
  int m_per  [NCH];
  int m_hi   [NCH];
  int m_nper [NCH];
  int m_nhi  [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];
  logic [2*NCH-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit level_of(input int pos, input int per, input int hi);
    if (hi == 0) return 1'b0;
    if (hi >= per) return 1'b1;
    return pos < hi;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = DP - 1; m_per[i] = DP; m_hi[i] = DH;
      m_nper[i] = DP; m_nhi[i] = DH; m_pend[i] = 1'b0;
      m_clk[i] = 1'b0; m_tick[i] = 1'b0;
    end
  endtask

  task automatic model_take(input int i);
    m_per[i] = m_nper[i];
    m_hi[i]  = m_nhi[i];
    m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input logic [NCH-1:0] e, input logic s, input logic v,
                            input int ch, input int p, input int h);
    bit acc;
    for (int i = 0; i < NCH; i++) begin
      acc = v && (ch == i) && !m_pend[i];
      if (s) begin
        if (m_pend[i]) model_take(i);
        m_pos[i] = 0;
        m_tick[i] = e[i];
        if (e[i]) m_clk[i] = level_of(0, m_per[i], m_hi[i]);
      end else if (e[i]) begin
        m_pos[i]++;
        if (m_pos[i] >= m_per[i]) begin
          m_pos[i] = 0;
          if (m_pend[i]) model_take(i);
        end
        m_tick[i] = (m_pos[i] == 0);
        m_clk[i]  = level_of(m_pos[i], m_per[i], m_hi[i]);
      end else begin
        m_tick[i] = 1'b0;
        if (m_pend[i]) begin
          model_take(i);
          m_pos[i] = m_per[i] - 1;
        end
      end
      if (acc) begin
        m_nper[i] = (p < 2) ? 2 : p;
        m_nhi[i]  = h;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic do_cycle(input logic [NCH-1:0] e, input logic s, input logic v,
                          input int ch, input int p, input int h);
    logic [2*NCH-1:0] exp;
    logic             exp_ready;
    @(negedge clk);
    en = e; sync = s; cfg_valid = v;
    cfg_ch = CHW'(ch); cfg_period = CW'(p); cfg_high = CW'(h);
    #1;
    exp_ready = 1'b1;
    if (ch < NCH) exp_ready = !m_pend[ch];
    check_val("cfg_ready", {31'b0, cfg_ready}, {31'b0, exp_ready});
    model_step(e, s, v, ch, p, h);
    for (int i = 0; i < NCH; i++) begin
      exp[i]       = m_clk[i];
      exp[NCH + i] = m_tick[i];
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_val("clk_out", {29'b0, clk_out}, {29'b0, exp[NCH-1:0]});
    check_val("tick", {29'b0, tick}, {29'b0, exp[2*NCH-1:NCH]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rst_clk_out", {29'b0, clk_out}, 32'd0);
    check_val("rst_tick", {29'b0, tick}, 32'd0);
    model_reset();
    @(negedge clk);
    en = '0; sync = 1'b0; cfg_valid = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] e;
    logic           s;
    rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    model_reset();
    #3;
    check_val("init_clk_out", {29'b0, clk_out}, 32'd0);
    check_val("init_tick", {29'b0, tick}, 32'd0);
    check_val("init_ready", {31'b0, cfg_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Default 10-cycle period, 5 high: ticks on cycles 1, 11, 21.
    for (int k = 1; k <= 25; k++) begin
      do_cycle('1, 1'b0, 1'b0, 0, 0, 0);
      check_val("dir_tick", {29'b0, tick}, (k % 10 == 1) ? 32'h7 : 32'h0);
      check_val("dir_clk", {29'b0, clk_out}, ((k - 1) % 10 < 5) ? 32'h7 : 32'h0);
    end

    // Narrow-pulse, clamped period, constant-0/1 and out-of-range writes.
    do_cycle('1, 1'b0, 1'b1, 0, 4, 1);
    do_cycle('1, 1'b0, 1'b1, 1, 1, 1);
    do_cycle('1, 1'b0, 1'b1, 3, 7, 2);
    for (int k = 0; k < 20; k++) do_cycle('1, 1'b0, 1'b0, 0, 0, 0);
    do_cycle('1, 1'b0, 1'b1, 1, 6, 0);
    for (int k = 0; k < 10; k++) do_cycle('1, 1'b0, 1'b0, 0, 0, 0);
    do_cycle('1, 1'b0, 1'b1, 1, 6, 9);
    for (int k = 0; k < 15; k++) do_cycle('1, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k < 7; k++)  do_cycle(3'b101, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k < 15; k++) do_cycle('1, 1'b0, 1'b0, 0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      if (k % 700 == 350) do_reset();
      for (int i = 0; i < NCH; i++) e[i] = ($urandom_range(0, 9) < 8);
`ifdef CLKDIV_SYNC_EN
      s = ($urandom_range(0, 40) == 0);
`else
      s = 1'b0;
`endif
      do_cycle(e, s, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 22)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
